// File: rtl/if_fetch_stage_if.sv
// Instruction-memory bus between the fetch stage and the instruction memory.
//   imem_req    fetch request; imem_addr valid while high      (fetch -> mem)
//   imem_addr   word-aligned fetch address                      (fetch -> mem)
//   imem_rdata  instruction word, valid with imem_ready         (mem -> fetch)
//   imem_ready  fetch completes this cycle                      (mem -> fetch)
interface if_fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;

  modport master (output imem_req, output imem_addr,
                  input  imem_rdata, input imem_ready);
  modport slave  (input  imem_req, input imem_addr,
                  output imem_rdata, output imem_ready);
endinterface

// File: rtl/if_fetch_stage.sv
// MIPS fetch stage: PC register, next-PC select, imem handshake and the IF/ID
// pipeline register. Branch/jump/jr redirects from decode are resolved with one
// architectural delay slot; if the delay-slot fetch has not completed when the
// redirect is accepted, the target waits in a 1-entry buffer (state PEND).
// Ports:
//   clk, reset     clock; asynchronous active-low reset
//   imem           imem bus (master side): req/addr out, rdata/ready in
//   stall          hazard unit hold of PC, IF/ID, state and pending target
//   redirect       decode requests a next-PC change (npc_sel selects type)
//   npc_sel        01 branch, 10 jump, 11 jr, 00 ignored
//   rs_val         jr target
//   id_valid/id_instr/id_pc4/id_imm16   IF/ID register contents
//   addr_err       one-cycle pulse after a jr with a misaligned target
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic                     clk,
  input  logic                     reset,
  if_fetch_stage_if.master         imem,
  input  logic                     stall,
  input  logic                     redirect,
  input  logic [1:0]               npc_sel,
  input  logic [31:0]              rs_val,
  output logic                     id_valid,
  output logic [31:0]              id_instr,
  output logic [31:0]              id_pc4,
  output logic [15:0]              id_imm16,
  output logic                     addr_err
);

  typedef enum logic [1:0] {BOOT, RUN, PEND} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] tgt_q, tgt_d;
  logic        err_d;
  logic [31:0] pc_plus4;
  logic [31:0] target;
  logic        fire;
  logic        accept;

  assign imem.imem_req  = (state_q != BOOT);
  assign imem.imem_addr = pc_q;
  assign id_imm16       = id_instr[15:0];
  assign pc_plus4       = pc_q + 32'd4;

  // A returned word only counts when the stage is not stalled.
  assign fire   = imem.imem_req & imem.imem_ready & ~stall;
  // Redirects are only taken in RUN; in PEND decode holds a bubble anyway.
  assign accept = (state_q == RUN) & redirect & id_valid & ~stall & (npc_sel != 2'b00);

  always_comb begin
    target = '0;
    case (npc_sel)
      2'b01:   target = id_pc4 + {{14{id_instr[15]}}, id_instr[15:0], 2'b00};
      2'b10:   target = {id_pc4[31:28], id_instr[25:0], 2'b00};
      2'b11:   target = {rs_val[31:2], 2'b00};
      default: target = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    err_d   = 1'b0;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (accept) begin
          err_d = (npc_sel == 2'b11) && (rs_val[1:0] != 2'b00);
          if (imem.imem_ready) begin
            pc_d = target;
          end else begin
            // Delay slot still outstanding: park the target, keep PC on it.
            tgt_d   = target;
            state_d = PEND;
          end
        end else if (fire) begin
          pc_d = pc_plus4;
        end
      end
      PEND: begin
        if (fire) begin
          pc_d    = tgt_q;
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= BOOT;
      pc_q     <= RESET_PC;
      tgt_q    <= '0;
      addr_err <= 1'b0;
    end else begin
      addr_err <= err_d;
      if (!stall || state_q == BOOT) begin
        state_q <= state_d;
      end
      if (!stall) begin
        pc_q  <= pc_d;
        tgt_q <= tgt_d;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      id_valid <= 1'b0;
      id_instr <= '0;
      id_pc4   <= '0;
    end else if (!stall) begin
      id_valid <= fire;
      if (fire) begin
        id_instr <= imem.imem_rdata;
        id_pc4   <= pc_plus4;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, redirect;
  logic [1:0]  npc_sel;
  logic [31:0] rs_val;
  logic        id_valid, addr_err;
  logic [31:0] id_instr, id_pc4;
  logic [15:0] id_imm16;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  if_fetch_stage_if imem_bus ();

  if_fetch_stage #(.RESET_PC(32'h0000_3000)) dut (
    .clk      (clk),
    .reset    (reset),
    .imem     (imem_bus),
    .stall    (stall),
    .redirect (redirect),
    .npc_sel  (npc_sel),
    .rs_val   (rs_val),
    .id_valid (id_valid),
    .id_instr (id_instr),
    .id_pc4   (id_pc4),
    .id_imm16 (id_imm16),
    .addr_err (addr_err)
  );

  typedef struct {
    logic        rst;
    logic        rdy;
    logic [31:0] rdata;
    logic        stl;
    logic        rdr;
    logic [1:0]  sel;
    logic [31:0] rs;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_v;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  localparam logic [31:0] B3 = 32'h1000_0003;
  localparam logic [31:0] BM = 32'h1000_FFFF;
  localparam logic [31:0] N1 = 32'h2400_0001;
  localparam logic [31:0] N2 = 32'h2400_0002;
  localparam logic [31:0] N3 = 32'h2400_0003;
  localparam logic [31:0] JW = 32'h0800_0C10;

  task automatic add(input logic rst, input logic rdy, input logic [31:0] rdata,
                     input logic stl, input logic rdr, input logic [1:0] sel,
                     input logic [31:0] rs, input logic e_req, input logic [31:0] e_addr,
                     input logic e_v, input logic [31:0] e_instr, input logic [31:0] e_pc4,
                     input logic e_err);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.rdata = rdata; v.stl = stl; v.rdr = rdr;
    v.sel = sel; v.rs = rs; v.e_req = e_req; v.e_addr = e_addr; v.e_v = e_v;
    v.e_instr = e_instr; v.e_pc4 = e_pc4; v.e_err = e_err;
    vecs.push_back(v);
  endtask

  task automatic check(input string tag, input logic e_req, input logic [31:0] e_addr,
                       input logic e_v, input logic [31:0] e_instr,
                       input logic [31:0] e_pc4, input logic e_err);
    n_tests++;
    if (imem_bus.imem_req !== e_req || imem_bus.imem_addr !== e_addr ||
        id_valid !== e_v || id_instr !== e_instr || id_pc4 !== e_pc4 ||
        id_imm16 !== e_instr[15:0] || addr_err !== e_err) begin
      n_fail++;
      $display("FAIL %s: got req=%0b addr=%h v=%0b instr=%h pc4=%h imm=%h err=%0b; want req=%0b addr=%h v=%0b instr=%h pc4=%h err=%0b",
               tag, imem_bus.imem_req, imem_bus.imem_addr, id_valid, id_instr, id_pc4,
               id_imm16, addr_err, e_req, e_addr, e_v, e_instr, e_pc4, e_err);
    end
  endtask

  task automatic drive(input logic rdy, input logic [31:0] rdata, input logic stl,
                       input logic rdr, input logic [1:0] sel, input logic [31:0] rs);
    imem_bus.imem_ready = rdy;
    imem_bus.imem_rdata = rdata;
    stall    = stl;
    redirect = rdr;
    npc_sel  = sel;
    rs_val   = rs;
  endtask

  // Reference model: one step per rising edge, following the fetch rules directly.
  bit          m_boot;
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_v, m_err;
  logic [31:0] m_pendq[$];

  task automatic model_reset();
    m_boot = 1; m_pc = 32'h0000_3000; m_pendq.delete();
    m_v = 0; m_instr = 0; m_pc4 = 0; m_err = 0;
  endtask

  task automatic model_edge(input logic rdy, input logic [31:0] rdata, input logic stl,
                            input logic rdr, input logic [1:0] sel, input logic [31:0] rs);
    logic [31:0] tgt, npc;
    bit take, acc;
    if (m_boot) begin
      m_boot = 0;
      m_err  = 0;
      if (!stl) m_v = 0;
      return;
    end
    take = rdy && !stl;
    acc  = rdr && m_v && !stl && sel != 2'd0 && m_pendq.size() == 0;
    case (sel)
      2'd1:    tgt = m_pc4 + 32'($signed(m_instr[15:0]) * 4);
      2'd2:    tgt = (m_pc4 & 32'hF000_0000) | ((m_instr & 32'h03FF_FFFF) << 2);
      default: tgt = rs & 32'hFFFF_FFFC;
    endcase
    m_err = acc && sel == 2'd3 && rs[1:0] != 2'd0;
    npc = m_pc;
    if (m_pendq.size() != 0) begin
      if (take) npc = m_pendq.pop_front();
    end else if (acc) begin
      if (rdy) npc = tgt;
      else m_pendq.push_back(tgt);
    end else if (take) begin
      npc = m_pc + 4;
    end
    if (!stl) begin
      m_v = rdy;
      if (rdy) begin
        m_instr = rdata;
        m_pc4   = m_pc + 4;
      end
    end
    m_pc = npc;
  endtask

  initial begin
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);

    // Boot, branch +3 with delay slot fetched immediately
    add(1,0,0,0,0,0,0,                0,32'h3000,0,0,0,0);
    add(0,1,32'hDEAD_BEEF,0,0,0,0,    0,32'h3000,0,0,0,0);
    add(0,1,B3,0,0,0,0,               1,32'h3000,0,0,0,0);
    add(0,1,N1,0,1,2'b01,0,           1,32'h3004,1,B3,32'h3004,0);
    add(0,1,N2,0,0,0,0,               1,32'h3010,1,N1,32'h3008,0);
    add(0,1,N3,0,0,0,0,               1,32'h3014,1,N2,32'h3014,0);
    // Branch -1 from id_pc4 0x3004
    add(1,0,0,0,0,0,0,                0,32'h3000,0,0,0,0);
    add(0,1,0,0,0,0,0,                0,32'h3000,0,0,0,0);
    add(0,1,BM,0,0,0,0,               1,32'h3000,0,0,0,0);
    add(0,1,N1,0,1,2'b01,0,           1,32'h3004,1,BM,32'h3004,0);
    add(0,1,N2,0,0,0,0,               1,32'h3000,1,N1,32'h3008,0);
    add(0,1,N3,0,0,0,0,               1,32'h3004,1,N2,32'h3004,0);
    // Branch with delay slot outstanding for 3 cycles (PEND)
    add(1,0,0,0,0,0,0,                0,32'h3000,0,0,0,0);
    add(0,1,0,0,0,0,0,                0,32'h3000,0,0,0,0);
    add(0,1,B3,0,0,0,0,               1,32'h3000,0,0,0,0);
    add(0,0,N1,0,1,2'b01,0,           1,32'h3004,1,B3,32'h3004,0);
    add(0,0,N1,0,1,2'b10,0,           1,32'h3004,0,B3,32'h3004,0);
    add(0,0,N1,0,1,2'b10,0,           1,32'h3004,0,B3,32'h3004,0);
    add(0,1,N1,0,1,2'b10,0,           1,32'h3004,0,B3,32'h3004,0);
    // Stall for 3 cycles with redirects pulsed
    add(0,1,N2,1,1,2'b10,0,           1,32'h3010,1,N1,32'h3008,0);
    add(0,1,32'h0BAD_0BAD,1,1,2'b11,32'h4000, 1,32'h3010,1,N1,32'h3008,0);
    add(0,0,32'h0BAD_0BAD,1,0,0,0,    1,32'h3010,1,N1,32'h3008,0);
    add(0,1,N2,0,0,0,0,               1,32'h3010,1,N1,32'h3008,0);
    // jr misaligned, jump, jr to top of memory, PC+4 wrap, npc_sel=00 ignored
    add(0,1,JW,0,1,2'b11,32'h3011,    1,32'h3014,1,N2,32'h3014,0);
    add(0,1,N3,0,1,2'b10,0,           1,32'h3010,1,JW,32'h3018,1);
    add(0,1,N1,0,1,2'b11,32'hFFFF_FFFC, 1,32'h3040,1,N3,32'h3014,0);
    add(0,1,N2,0,0,0,0,               1,32'hFFFF_FFFC,1,N1,32'h3044,0);
    add(0,1,N3,0,1,2'b00,0,           1,32'h0000_0000,1,N2,32'h0000_0000,0);
    add(0,1,N1,0,0,0,0,               1,32'h0000_0004,1,N3,32'h0000_0004,0);

    foreach (vecs[i]) begin
      @(negedge clk);
      reset = ~vecs[i].rst;
      drive(vecs[i].rdy, vecs[i].rdata, vecs[i].stl, vecs[i].rdr, vecs[i].sel, vecs[i].rs);
      #1;
      check($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_v,
            vecs[i].e_instr, vecs[i].e_pc4, vecs[i].e_err);
    end

    // Reset asserted mid-cycle while in PEND; buffered target must be dropped
    @(negedge clk); reset = 0; drive(1, 0, 0, 0, 0, 0);
    @(negedge clk); reset = 1;
    @(negedge clk); drive(1, B3, 0, 0, 0, 0);
    @(negedge clk); drive(0, N1, 0, 1, 2'b01, 0);
    @(negedge clk); drive(0, N1, 0, 0, 0, 0);
    #1 check("pend_hold", 1, 32'h3004, 0, B3, 32'h3004, 0);
    #2 reset = 0;
    #1 check("pend_reset", 0, 32'h3000, 0, 0, 0, 0);
    @(negedge clk); reset = 1; drive(1, N1, 0, 0, 0, 0);
    #1 check("pend_boot", 0, 32'h3000, 0, 0, 0, 0);
    @(negedge clk);
    #1 check("pend_fetch0", 1, 32'h3000, 0, 0, 0, 0);
    @(negedge clk);
    #1 check("pend_fetch1", 1, 32'h3004, 1, N1, 32'h3004, 0);

    // Randomized run against the reference model
    @(negedge clk); reset = 0; drive(0, 0, 0, 0, 0, 0);
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      bit do_rst;
      logic rdy, stl, rdr;
      logic [1:0] sel;
      logic [31:0] rs, rd;
      @(negedge clk);
      do_rst = ($urandom_range(0, 199) == 0);
      rdy = ($urandom_range(0, 9) < 7);
      stl = ($urandom_range(0, 9) < 2);
      rdr = ($urandom_range(0, 9) < 4);
      sel = 2'($urandom_range(0, 3));
      rs  = $urandom;
      if ($urandom_range(0, 1) == 0) rs[1:0] = 2'b00;
      rd  = $urandom;
      reset = ~do_rst;
      if (do_rst) model_reset();
      drive(rdy, rd, stl, rdr, sel, rs);
      #1;
      check($sformatf("rand%0d", i), !m_boot, m_pc, m_v, m_instr, m_pc4, m_err);
      @(posedge clk);
      if (!do_rst) model_edge(rdy, rd, stl, rdr, sel, rs);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
